// File: rtl/sub_share_arbiter_pkg.sv
// Shared types, constants and the signed-subtract overflow helper for the
// shared-subtractor arbiter.
package sub_share_pkg;

  localparam int         OP_W        = 8;
  localparam logic [7:0] OVF_CNT_MAX = 8'hFF;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  // Two's-complement overflow of a - b, judged on the raw operands so that
  // b = -128 needs no special case.
  function automatic logic sub_ovf(input logic [OP_W-1:0] a,
                                   input logic [OP_W-1:0] b,
                                   input logic [OP_W-1:0] d);
    return (a[OP_W-1] != b[OP_W-1]) && (d[OP_W-1] != a[OP_W-1]);
  endfunction

endpackage

// File: rtl/sub_share_arbiter_if.sv
// Requester and response bundle of the shared subtractor; slave is the
// arbiter side, master is the client/environment side.
interface sub_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_A;
  logic [NREQ*8-1:0] req_B;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_result;
  logic              rsp_overflow;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        ovf_count;
  logic              ovf_clr;

  modport slave (
    input  req_valid, req_A, req_B, rsp_ready, ovf_clr,
    output req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_id, ovf_count
  );

  modport master (
    output req_valid, req_A, req_B, rsp_ready, ovf_clr,
    input  req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_id, ovf_count
  );
endinterface

// File: rtl/sub_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches upward from a rotating priority pointer and
// moves the pointer past the winner whenever a grant is consumed.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any_grant
);

  logic [IDW-1:0] ptr;

  function automatic int wrap_idx(input int base, input int k);
    int j;
    j = base + k;
    if (j >= NREQ) j = j - NREQ;
    return j;
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // it unassigned and no latch is inferred.
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_grant && req[wrap_idx(int'(ptr), k)]) begin
        any_grant                        = 1'b1;
        grant[wrap_idx(int'(ptr), k)]    = 1'b1;
        idx                              = IDW'(wrap_idx(int'(ptr), k));
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(idx) == NREQ - 1) ? '0 : idx + IDW'(1);
    end
  end

endmodule

// File: rtl/sub_share_arbiter.sv
// Shares one 8-bit signed subtractor among NREQ requesters with round-robin
// arbitration, a single-entry result stage and a saturating overflow counter.
module sub_share_arbiter
  import sub_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sub_share_arbiter_if.slave     bus
);

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_idx;
  logic            any_grant;
  logic            can_accept;
  logic            accept;
  logic [OP_W-1:0] a_sel;
  logic [OP_W-1:0] b_sel;
  logic [OP_W-1:0] diff;
  logic            diff_ovf;

  stage_state_e    state_q;
  stage_state_e    state_d;
  logic            rsp_valid;

  logic [OP_W-1:0] result_q;
  logic            overflow_q;
  logic [IDW-1:0]  id_q;
  logic [7:0]      ovf_cnt_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .advance   (accept),
    .grant     (grant),
    .idx       (win_idx),
    .any_grant (any_grant)
  );

  // A full stage being drained this cycle can take a new op: 1 op/cycle.
  assign can_accept = !rsp_valid || bus.rsp_ready;
  assign accept     = any_grant && can_accept && !rst;
  assign bus.req_ready = rst ? '0 : (grant & {NREQ{can_accept}});

  // Single shared subtractor fed through the grant mux.
  assign a_sel    = bus.req_A[win_idx*OP_W +: OP_W];
  assign b_sel    = bus.req_B[win_idx*OP_W +: OP_W];
  assign diff     = a_sel - b_sel;
  assign diff_ovf = sub_ovf(a_sel, b_sel, diff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept)             state_d = ST_FULL;
        else if (bus.rsp_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid = (state_q == ST_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      id_q       <= '0;
    end else if (accept) begin
      result_q   <= diff;
      overflow_q <= diff_ovf;
      id_q       <= win_idx;
    end
  end

  // Clear wins over a coincident overflow increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else if (bus.ovf_clr) begin
      ovf_cnt_q <= '0;
    end else if (accept && diff_ovf && (ovf_cnt_q != OVF_CNT_MAX)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_result   = result_q;
  assign bus.rsp_overflow = overflow_q;
  assign bus.rsp_id       = id_q;
  assign bus.ovf_count    = ovf_cnt_q;

endmodule
